// File: rtl/sisc_mc_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sisc_mc_core_if
// Brief    : Instruction/data memory handshake bundle for sisc_mc_core.
// Revision : 1.0
// ============================================================================
interface sisc_mc_core_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sisc_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : sisc_mc_core
// Brief    : Multi-cycle SISC core (FETCH/DECODE/EXEC/MEM/WB/HALT).
//            Define SISC_RETIRE_CNT_EN to build the retired-instruction counter.
// Revision : 1.0
// ============================================================================
module sisc_mc_core #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int ADDR_W = 16
) (
    input  logic           clk,
    input  logic           rst_f,
    sisc_mc_core_if.master bus,
    output logic [3:0]     stat,
    output logic           halted,
    output logic [31:0]    retired
);
    localparam int RI_W = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int MSB  = DATA_W - 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Register fields wrap modulo NREG so small register files alias cleanly.
    function automatic logic [RI_W-1:0] ridx(input logic [3:0] f);
        int m;
        m = int'(f) % NREG;
        return RI_W'(m);
    endfunction

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [3:0]        stat_q;
    logic              halted_q;
    logic              imem_req_q;
    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [DATA_W-1:0] dmem_wdata_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [RI_W-1:0]   wb_idx_q;
    logic [DATA_W-1:0] regs_q [NREG];

    logic [3:0]        opcode;
    logic [3:0]        mm;
    logic [RI_W-1:0]   rs_idx;
    logic [RI_W-1:0]   rt_idx;
    logic [RI_W-1:0]   rd_idx;
    logic [31:0]       imm_sx32;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        shamt;
    logic              sh_big;
    logic [DATA_W-1:0] alu_res_d;
    logic              alu_c;
    logic              alu_v;
    logic              alu_ok;
    logic              is_alu;
    logic [3:0]        stat_d;
    logic [ADDR_W-1:0] ea_d;
    logic [ADDR_W-1:0] pc_br_d;
    logic              br_take;

    assign opcode   = ir_q[31:28];
    assign mm       = ir_q[27:24];
    assign rs_idx   = ridx(ir_q[23:20]);
    assign rt_idx   = ridx(ir_q[19:16]);
    assign rd_idx   = ridx(ir_q[15:12]);
    assign imm_sx32 = {{16{ir_q[15]}}, ir_q[15:0]};

    assign alu_b  = (opcode == 4'h2) ? DATA_W'(imm_sx32) : opb_q;
    assign shamt  = alu_b[4:0];
    assign sh_big = (int'(shamt) >= DATA_W);

    always_comb begin
        alu_res_d = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_ok    = 1'b1;
        case (mm)
            4'd0: begin
                {alu_c, alu_res_d} = {1'b0, opa_q} + {1'b0, alu_b};
                alu_v = (opa_q[MSB] == alu_b[MSB]) && (alu_res_d[MSB] != opa_q[MSB]);
            end
            4'd1: begin
                // Carry on subtract is the borrow out of the DATA_W-bit difference.
                {alu_c, alu_res_d} = {1'b0, opa_q} - {1'b0, alu_b};
                alu_v = (opa_q[MSB] != alu_b[MSB]) && (alu_res_d[MSB] != opa_q[MSB]);
            end
            4'd2:    alu_res_d = opa_q & alu_b;
            4'd3:    alu_res_d = opa_q | alu_b;
            4'd4:    alu_res_d = opa_q ^ alu_b;
            4'd5:    alu_res_d = ~opa_q;
            4'd6:    alu_res_d = sh_big ? '0 : (opa_q << shamt);
            4'd7:    alu_res_d = sh_big ? '0 : (opa_q >> shamt);
            default: alu_ok = 1'b0;
        endcase
    end

    assign is_alu  = ((opcode == 4'h1) || (opcode == 4'h2)) && alu_ok;
    assign stat_d  = {alu_c, alu_v, alu_res_d[MSB], (alu_res_d == '0)};
    assign ea_d    = ADDR_W'(32'(opa_q) + imm_sx32);
    assign pc_br_d = pc_q + ADDR_W'(imm_sx32);
    assign br_take = (mm == 4'd0) || ((stat_q & mm) != 4'd0);

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            stat_q     <= '0;
            halted_q   <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // An ack only counts while our own request is visible.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir_q       <= bus.imem_rdata;
                        pc_q       <= pc_q + ADDR_W'(1);
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opa_q   <= regs_q[rs_idx];
                    opb_q   <= regs_q[rt_idx];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (opcode)
                        4'h1, 4'h2: begin
                            if (alu_ok) begin
                                stat_q    <= stat_d;
                                wb_data_q <= alu_res_d;
                                wb_idx_q  <= (opcode == 4'h1) ? rd_idx : rt_idx;
                                state_q   <= S_WB;
                            end else begin
                                state_q    <= S_FETCH;
                                imem_req_q <= 1'b1;
                            end
                        end
                        4'h4: begin
                            if (br_take) begin
                                pc_q <= pc_br_d;
                            end
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                        4'h8, 4'h9: begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (opcode == 4'h9);
                            dmem_addr_q  <= ea_d;
                            dmem_wdata_q <= opb_q;
                            state_q      <= S_MEM;
                        end
                        4'hF: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: begin
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        if (dmem_we_q) begin
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end else begin
                            wb_data_q <= bus.dmem_rdata;
                            wb_idx_q  <= rt_idx;
                            state_q   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_f && (state_q == S_WB)) begin
            regs_q[wb_idx_q] <= wb_data_q;
        end
    end

`ifdef SISC_RETIRE_CNT_EN
    logic        retire_w;
    logic [31:0] retired_q;

    assign retire_w = (state_q == S_WB)
                   || ((state_q == S_MEM) && bus.dmem_ack && dmem_we_q)
                   || ((state_q == S_EXEC) && !(is_alu || (opcode == 4'h8) || (opcode == 4'h9)));

    always_ff @(posedge clk) begin
        if (rst_f) begin
            retired_q <= '0;
        end else if (retire_w) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign stat           = stat_q;
    assign halted         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_sisc_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sisc_mc_core
// Brief    : Directed self-checking bench for sisc_mc_core with a store scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sisc_mc_core;
    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  stat;
    logic        halted;
    logic [31:0] retired;
    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q [$];

    sisc_mc_core_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    sisc_mc_core #(.DATA_W(32), .NREG(16), .ADDR_W(16)) dut (
        .clk     (clk),
        .rst_f   (rst_f),
        .bus     (bus),
        .stat    (stat),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] f_alu(input logic [3:0] m, rs, rt, rd);
        return {4'h1, m, rs, rt, rd, 12'h000};
    endfunction
    function automatic logic [31:0] f_alui(input logic [3:0] m, rs, rt, input logic [15:0] imm);
        return {4'h2, m, rs, rt, imm};
    endfunction
    function automatic logic [31:0] f_br(input logic [3:0] m, input logic [15:0] imm);
        return {4'h4, m, 8'h00, imm};
    endfunction
    function automatic logic [31:0] f_ld(input logic [3:0] rs, rt, input logic [15:0] imm);
        return {4'h8, 4'h0, rs, rt, imm};
    endfunction
    function automatic logic [31:0] f_st(input logic [3:0] rs, rt, input logic [15:0] imm);
        return {4'h9, 4'h0, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ireq();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 64) begin
            wait_cyc();
            n++;
        end
    endtask

    task automatic wait_dreq();
        int n = 0;
        while (bus.dmem_req !== 1'b1 && n < 64) begin
            wait_cyc();
            n++;
        end
    endtask

    task automatic fetch(input logic [15:0] a, input logic [31:0] ins, input int dly);
        wait_ireq();
        chk("fetch_req", bus.imem_req, 1);
        chk("fetch_addr", bus.imem_addr, a);
        if (dly > 0) begin
            repeat (dly) wait_cyc();
            chk("fetch_addr_hold", {bus.imem_req, bus.imem_addr}, {1'b1, a});
        end
        bus.imem_rdata = ins;
        bus.imem_ack   = 1'b1;
        wait_cyc();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
    endtask

    task automatic expect_stat(input string tag, input logic [3:0] s);
        wait_ireq();
        chk(tag, stat, s);
    endtask

    task automatic load(input logic [15:0] a, input logic [31:0] d, input int dly);
        int hi;
        wait_dreq();
        chk("load_we", bus.dmem_we, 0);
        chk("load_addr", bus.dmem_addr, a);
        hi = (bus.dmem_req === 1'b1) ? 1 : 0;
        repeat (dly) begin
            wait_cyc();
            if (bus.dmem_req === 1'b1) hi++;
        end
        chk("load_addr_hold", bus.dmem_addr, a);
        bus.dmem_rdata = d;
        bus.dmem_ack   = 1'b1;
        wait_cyc();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        if (bus.dmem_req === 1'b1) hi++;
        chk("load_req_cycles", hi, dly + 1);
    endtask

    task automatic store(input int dly);
        logic [47:0] e;
        wait_dreq();
        chk("store_we", bus.dmem_we, 1);
        repeat (dly) wait_cyc();
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=store expected=none");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("store_addr_data", {bus.dmem_addr, bus.dmem_wdata}, e);
        end
        bus.dmem_ack = 1'b1;
        wait_cyc();
        bus.dmem_ack = 1'b0;
    endtask

    initial begin
        int hi;
        rst_f = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (3) wait_cyc();
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_dmem_req", bus.dmem_req, 0);
        chk("rst_pc", bus.imem_addr, 0);
        chk("rst_stat", stat, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        rst_f = 1'b0;

        // Clear R0, then ADDI R1 = R0 + 5.
        fetch(16'd0, f_alu(4'd4, 4'd0, 4'd0, 4'd0), 0);
        expect_stat("xor_zero_stat", 4'b0001);
        fetch(16'd1, f_alui(4'd0, 4'd0, 4'd1, 16'h0005), 2);
        expect_stat("addi_stat", 4'b0000);
        fetch(16'd2, f_ld(4'd0, 4'd2, 16'h0020), 0);
        load(16'h0020, 32'h7FFF_FFFF, 3);
        fetch(16'd3, f_ld(4'd0, 4'd3, 16'h0021), 0);
        load(16'h0021, 32'h0000_0001, 1);
        fetch(16'd4, f_alu(4'd1, 4'd1, 4'd1, 4'd4), 0);
        wait_ireq();
        chk("sub_zero_stat", {1'b0, stat[2:0]}, 4'b0001);
        fetch(16'd5, f_br(4'd1, 16'hFFFE), 0);
        fetch(16'd4, f_alu(4'd0, 4'd2, 4'd3, 4'd5), 0);
        expect_stat("add_ovf_stat", 4'b0110);
        fetch(16'd5, f_br(4'd1, 16'hFFFE), 0);
        exp_q.push_back({16'h0030, 32'h8000_0000});
        fetch(16'd6, f_st(4'd0, 4'd5, 16'h0030), 0);
        store(2);

        fetch(16'd7, f_alui(4'd0, 4'd1, 4'd6, 16'hFFFF), 0);
        expect_stat("addi_carry_stat", 4'b1000);
        fetch(16'd8, f_alui(4'd6, 4'd1, 4'd7, 16'h0004), 0);
        fetch(16'd9, f_alui(4'd7, 4'd2, 4'd8, 16'h001F), 0);
        expect_stat("shr_zero_stat", 4'b0001);
        fetch(16'd10, f_alu(4'd5, 4'd3, 4'd0, 4'd9), 0);
        expect_stat("not_stat", 4'b0010);
        fetch(16'd11, f_alu(4'd2, 4'd2, 4'd1, 4'd10), 0);
        fetch(16'd12, f_alui(4'd3, 4'd1, 4'd11, 16'h00F0), 0);
        fetch(16'd13, f_alu(4'd0, 4'd1, 4'd1, 4'd1), 0);
        fetch(16'd14, 32'h3123_4567, 0);
        fetch(16'd15, f_br(4'd0, 16'h0002), 0);

        exp_q.push_back({16'h0040, 32'h0000_0004});
        fetch(16'd18, f_st(4'd0, 4'd6, 16'h0040), 0);  store(0);
        exp_q.push_back({16'h0041, 32'h0000_0050});
        fetch(16'd19, f_st(4'd0, 4'd7, 16'h0041), 0);  store(0);
        exp_q.push_back({16'h0042, 32'h0000_0000});
        fetch(16'd20, f_st(4'd0, 4'd8, 16'h0042), 0);  store(0);
        exp_q.push_back({16'h0043, 32'hFFFF_FFFE});
        fetch(16'd21, f_st(4'd0, 4'd9, 16'h0043), 0);  store(0);
        exp_q.push_back({16'h0044, 32'h0000_0005});
        fetch(16'd22, f_st(4'd0, 4'd10, 16'h0044), 0); store(0);
        exp_q.push_back({16'h0045, 32'h0000_00F5});
        fetch(16'd23, f_st(4'd0, 4'd11, 16'h0045), 0); store(0);
        exp_q.push_back({16'h0046, 32'h0000_000A});
        fetch(16'd24, f_st(4'd0, 4'd1, 16'h0046), 0);  store(1);
        fetch(16'd25, f_ld(4'd1, 4'd12, 16'hFFFE), 0);
        load(16'h0008, 32'h1234_5678, 0);
        exp_q.push_back({16'h0047, 32'h1234_5678});
        fetch(16'd26, f_st(4'd0, 4'd12, 16'h0047), 0); store(0);
        fetch(16'd27, 32'hF000_0000, 0);
        repeat (3) wait_cyc();
        chk("halt_flag", halted, 1);
        hi = 0;
        repeat (10) begin
            wait_cyc();
            if (bus.imem_req !== 1'b0) hi++;
        end
        chk("halt_no_fetch", hi, 0);

        // Reset out of HALT, then reset again during a stalled load.
        rst_f = 1'b1;
        wait_cyc();
        chk("rst2_halted", halted, 0);
        chk("rst2_stat", stat, 0);
        rst_f = 1'b0;
        fetch(16'd0, f_ld(4'd0, 4'd1, 16'h0050), 0);
        wait_dreq();
        chk("mem_wait_req", bus.dmem_req, 1);
        rst_f = 1'b1;
        wait_cyc();
        chk("rst_mem_dreq", bus.dmem_req, 0);
        chk("rst_mem_ireq", bus.imem_req, 0);
        chk("rst_mem_pc", bus.imem_addr, 0);
        rst_f = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hF000_0000; bus.dmem_ack = 1'b1;
        wait_cyc();
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
        chk("late_ack_halted", halted, 0);
        chk("late_ack_fetch_req", bus.imem_req, 1);

        fetch(16'd0, f_alu(4'd0, 4'd1, 4'd1, 4'd2), 0);
        fetch(16'd1, f_alu(4'd4, 4'd2, 4'd2, 4'd3), 0);
        fetch(16'd2, f_alui(4'd0, 4'd0, 4'd4, 16'h0007), 0);
        fetch(16'd3, 32'hF000_0000, 0);
        repeat (3) wait_cyc();
        chk("halt2_flag", halted, 1);
`ifdef SISC_RETIRE_CNT_EN
        chk("retired_count", retired, 32'd4);
`else
        chk("retired_const0", retired, 32'd0);
`endif
        hi = 0;
        repeat (8) begin
            wait_cyc();
            if (bus.imem_req !== 1'b0) hi++;
        end
        chk("halt2_no_fetch", hi, 0);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sisc_mc_core.md
SISC_MC_CORE -- requirements
Module: sisc_mc_core

Interface
REQ-001: Parameter DATA_W, default 32, datapath and register width (16..32).
REQ-002: Parameter NREG, default 16, register count (2..16); register fields decode modulo NREG.
REQ-003: Parameter ADDR_W, default 16, instruction and data address width.
REQ-004: clk  in  1  single clock; all state updates on rising edge.
REQ-005: rst_f  in  1  reset, synchronous, active-high.
REQ-006: imem_req  out  1  instruction fetch request; imem_addr  out  ADDR_W  fetch address (PC).
REQ-007: imem_ack  in  1  fetch complete; imem_rdata  in  32  instruction, valid when imem_ack=1.
REQ-008: dmem_req  out  1  data access request; dmem_we  out  1  1=store.
REQ-009: dmem_addr  out  ADDR_W  data address; dmem_wdata  out  DATA_W  store data.
REQ-010: dmem_ack  in  1  data access complete; dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1.
REQ-011: stat  out  4  status flags {C,V,N,Z}; halted  out  1  core stopped.
REQ-012: retired  out  32  retired-instruction count (see Configuration).

Function
REQ-013: Instruction fields: opcode[31:28], mm[27:24], rs[23:20], rt[19:16], rd[15:12], imm[15:0].
REQ-014: FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; transitions at clock edges only.
REQ-015: FETCH: imem_req=1, imem_addr=PC, held until imem_ack; on ack, IR<=imem_rdata, PC<=PC+1 (mod 2^ADDR_W), go to DECODE.
REQ-016: DECODE: read R[rs], R[rt] into operand latches; go to EXEC.
REQ-017: Opcode 0 NOP: EXEC -> FETCH.
REQ-018: Opcode 1 ALU-reg: result=R[rs] op R[rt], op by mm: 0 ADD, 1 SUB (rs-rt), 2 AND, 3 OR, 4 XOR, 5 NOT rs, 6 SHL rs by rt[4:0], 7 SHR logical; others NOP; write rd in WB.
REQ-019: Opcode 2 ALU-imm: as opcode 1 with rt operand replaced by imm sign-extended to DATA_W; write rt in WB.
REQ-020: ALU opcodes update stat in EXEC: Z=(result==0), N=result[DATA_W-1]; C, V from ADD/SUB at DATA_W bits, else C, V cleared.
REQ-021: Shift amounts >= DATA_W yield 0.
REQ-022: Opcode 4 branch: taken if (stat & mm)!=0, or mm==0 (unconditional); taken: PC<=PC+sign_ext(imm) in EXEC, using the already-incremented PC; EXEC -> FETCH.
REQ-023: Opcode 8 LOAD: addr=R[rs]+sign_ext(imm) truncated to ADDR_W; MEM holds dmem_req=1, dmem_we=0 until dmem_ack; WB writes dmem_rdata to rt.
REQ-024: Opcode 9 STORE: as LOAD address; dmem_we=1, dmem_wdata=R[rt]; MEM -> FETCH on ack; no register write.
REQ-025: Opcode F HALT: enter HALT; halted=1; remain until reset.
REQ-026: Undefined opcodes execute as NOP.
REQ-027: R0 is an ordinary writable register; rs==rd reads the pre-write value.
REQ-028: dmem_addr, dmem_we and dmem_wdata stable while dmem_req=1; imem_addr stable while imem_req=1.
REQ-029: An instruction retires on its final state transition back to FETCH or into HALT.

Reset
REQ-030: rst_f=1 at an edge: state<=FETCH, PC<=0, IR<=0, stat<=0, halted<=0, retired<=0, imem_req and dmem_req deasserted the next cycle.
REQ-031: Reset aborts any pending access; a late ack after reset is ignored unless it arrives while FETCH is requesting.
REQ-032: Register file contents are not reset.

Configuration
REQ-033: Macro SISC_RETIRE_CNT_EN defined: retired increments by 1 per retired instruction, wrapping at 2^32; HALT counts once.
REQ-034: Macro SISC_RETIRE_CNT_EN undefined: retired is constant 0 and no counter logic is built.

Verification
REQ-035: Reset, imem returns {2,0,0,1,0005}, acks immediate -> after WB, R1=5, stat=0000, PC=1.
REQ-036: R1=0x7FFFFFFF, R2=1, ADD R3=R1+R2 -> R3=0x80000000, stat N=1, V=1, C=0, Z=0.
REQ-037: SUB to zero, then branch mm=0001, imm=-2 at PC=5 -> next fetch addr 4; with Z=0 -> fetch addr 6.
REQ-038: LOAD with dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, addr constant, rt written with dmem_rdata.
REQ-039: rst_f asserted during MEM wait -> next cycle dmem_req=0; then FETCH at addr 0.
REQ-040: With SISC_RETIRE_CNT_EN, 3 ALU ops then HALT -> retired=4, halted=1, no further imem_req.
